dm_access_ctrl: RTL and testbench

- Multi-cycle data-memory access controller for the MEM stage of the 5-stage RV32I pipeline.
- Takes the EX/MEM load/store request, drives the data SRAM port, and waits a fixed SRAM latency.
- Returns byte/half/word-extended load data.
- Asserts mem_busy to the hazard control unit, which uses it as the memory-stall enable that freezes PC and the pipeline registers.

---
 rtl/dm_ctrl_pkg.sv | 22 ++
 rtl/dm_access_ctrl_load_extend.sv | 22 ++
 rtl/dm_access_ctrl.sv | 118 +++++++++++
 tb/tb_dm_access_ctrl.sv | 131 +++++++++++++
 4 files changed

// File: rtl/dm_ctrl_pkg.sv
// dm_ctrl_pkg: funct3 codes, FSM states and request decode helpers for dm_access_ctrl
package dm_ctrl_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [3:0] WEB_NONE = 4'hF;
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} dm_state_e;
  function automatic logic f_bad(input logic we, input logic [2:0] f3, input logic [1:0] a);
    logic ill, mis;
    ill = f3 == 3'b011 || f3[2:1] == 2'b11 || (f3[2] && we);
    mis = (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a != 2'b00);
    return ill || mis;
  endfunction
  function automatic logic [3:0] f_web(input logic [2:0] f3, input logic [1:0] a);
    return f3 == F3_B ? ~(4'b0001 << a) : f3 == F3_H ? (a[1] ? 4'b0011 : 4'b1100) : 4'h0;
  endfunction
  function automatic logic [31:0] f_di(input logic [2:0] f3, input logic [31:0] wd);
    return f3 == F3_B ? {4{wd[7:0]}} : f3 == F3_H ? {2{wd[15:0]}} : wd;
  endfunction
endpackage

// File: rtl/dm_access_ctrl_load_extend.sv
// load_extend: selects the addressed byte/half of a read word and sign/zero extends it
//   i_do[31:0] SRAM word, i_funct3 load type, i_a byte offset -> o_data extended result
module load_extend
  import dm_ctrl_pkg::*;
(
  input  logic [31:0] i_do,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_a,
  output logic [31:0] o_data
);
  logic [31:0] w_sh;
  logic [7:0]  w_b;
  logic [15:0] w_h;
  assign w_sh = i_do >> {i_a, 3'b000};
  assign w_b  = w_sh[7:0];
  assign w_h  = i_a[1] ? i_do[31:16] : i_do[15:0];
  always_comb
    o_data = i_funct3 == F3_B  ? {{24{w_b[7]}}, w_b} :
             i_funct3 == F3_BU ? {24'b0, w_b} :
             i_funct3 == F3_H  ? {{16{w_h[15]}}, w_h} :
             i_funct3 == F3_HU ? {16'b0, w_h} : i_do;
endmodule

// File: rtl/dm_access_ctrl.sv
// dm_access_ctrl: MEM-stage multi-cycle data SRAM controller with stall and load extension
//   in : clk, rst (async active-low), req_valid/we/funct3/addr/wdata from EX/MEM, DM_DO from SRAM
//   out: DM_CS/OE/WEB/A/DI to SRAM, mem_busy to hazard unit, rdata_valid/rdata, misalign_err
//   DM_PERF_CNT_EN defined adds load_cnt and stall_cnt counters
module dm_access_ctrl
  import dm_ctrl_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter int RD_LAT = 1,
  parameter int WR_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              DM_CS,
  output logic              DM_OE,
  output logic [3:0]        DM_WEB,
  output logic [ADDR_W-1:0] DM_A,
  output logic [31:0]       DM_DI,
  input  logic [31:0]       DM_DO,
  output logic              mem_busy,
  output logic              rdata_valid,
  output logic [31:0]       rdata,
  output logic              misalign_err
`ifdef DM_PERF_CNT_EN
  ,
  output logic [31:0]       load_cnt,
  output logic [31:0]       stall_cnt
`endif
);
  dm_state_e         r_state;
  logic [1:0]        r_cnt, r_a;
  logic              r_we, r_cs, r_oe, r_rv, r_err;
  logic [2:0]        r_f3;
  logic [3:0]        r_web;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_di, r_rd, w_ext;
  logic [1:0]        w_lat;
  logic              w_fin, w_unused;
  assign w_unused = ^req_addr[31:ADDR_W+2];
  assign w_lat = r_we ? 2'(WR_LAT - 1) : 2'(RD_LAT - 1);
  // last cycle the SRAM port is held; DO is sampled on the edge that ends it
  assign w_fin = (r_state == ACCESS && w_lat == 2'd0) || (r_state == WAIT && r_cnt == 2'd1);
  assign mem_busy = r_state == IDLE ? req_valid : (r_state == ACCESS || r_state == WAIT);
  assign {DM_CS, DM_OE, DM_WEB, DM_A, DM_DI} = {r_cs, r_oe, r_web, r_addr, r_di};
  assign {rdata_valid, rdata, misalign_err} = {r_rv, r_rd, r_err};
  load_extend u_ext (.i_do(DM_DO), .i_funct3(r_f3), .i_a(r_a), .o_data(w_ext));
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_we    <= 1'b0;
      r_f3    <= '0;
      r_cs    <= 1'b0;
      r_oe    <= 1'b0;
      r_web   <= WEB_NONE;
      r_addr  <= '0;
      r_di    <= '0;
      r_rv    <= 1'b0;
      r_rd    <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE:
          if (req_valid) begin
            r_we   <= req_we;
            r_f3   <= req_funct3;
            r_a    <= req_addr[1:0];
            r_addr <= req_addr[ADDR_W+1:2];
            if (f_bad(req_we, req_funct3, req_addr[1:0])) begin
              r_state <= DONE;
              r_err   <= 1'b1;
              r_rd    <= '0;
            end else begin
              r_state <= ACCESS;
              r_cs    <= 1'b1;
              r_oe    <= !req_we;
              r_web   <= req_we ? f_web(req_funct3, req_addr[1:0]) : WEB_NONE;
              r_di    <= req_we ? f_di(req_funct3, req_wdata) : r_di;
            end
          end
        ACCESS, WAIT: begin
          r_cnt <= r_state == ACCESS ? w_lat : r_cnt - 2'd1;
          if (w_fin) begin
            r_state <= DONE;
            r_cs    <= 1'b0;
            r_oe    <= 1'b0;
            r_web   <= WEB_NONE;
            r_rv    <= !r_we;
            r_rd    <= r_we ? r_rd : w_ext;
          end else
            r_state <= WAIT;
        end
        default: begin
          r_state <= IDLE;
          r_rv    <= 1'b0;
          r_err   <= 1'b0;
        end
      endcase
    end
`ifdef DM_PERF_CNT_EN
  logic [31:0] r_load_cnt, r_stall_cnt;
  assign {load_cnt, stall_cnt} = {r_load_cnt, r_stall_cnt};
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_load_cnt  <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_load_cnt  <= r_load_cnt + 32'(r_rv);
      r_stall_cnt <= r_stall_cnt + 32'(mem_busy);
    end
`endif
endmodule

// File: tb/tb_dm_access_ctrl.sv
// tb_dm_access_ctrl: directed vectors against two dm_access_ctrl instances (RD/WR lat 1/1 and 3/2)
module tb_dm_access_ctrl;
  logic        clk = 1'b0;
  logic        rst_a = 1'b0, rst_b = 1'b0, sel = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0, req_wdata = '0, dm_do = '0;
  logic        cs_a, oe_a, busy_a, rv_a, err_a, cs_b, oe_b, busy_b, rv_b, err_b;
  logic [3:0]  web_a, web_b;
  logic [13:0] a_a, a_b;
  logic [31:0] di_a, di_b, rd_a, rd_b;
  logic        m_cs, m_oe, m_busy, m_rv, m_err;
  logic [3:0]  m_web;
  logic [13:0] m_a;
  logic [31:0] m_di, m_rd;
  int          n_vec = 0, n_err = 0;
`ifdef DM_PERF_CNT_EN
  logic [31:0] lc_a, sc_a, lc_b, sc_b;
`endif
  always #5 clk = ~clk;
  dm_access_ctrl #(.ADDR_W(14), .RD_LAT(1), .WR_LAT(1)) u_dut_a (
    .clk(clk), .rst(rst_a), .req_valid(req_valid && !sel), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .DM_CS(cs_a), .DM_OE(oe_a), .DM_WEB(web_a), .DM_A(a_a), .DM_DI(di_a), .DM_DO(dm_do),
    .mem_busy(busy_a), .rdata_valid(rv_a), .rdata(rd_a), .misalign_err(err_a)
`ifdef DM_PERF_CNT_EN
    , .load_cnt(lc_a), .stall_cnt(sc_a)
`endif
  );
  dm_access_ctrl #(.ADDR_W(14), .RD_LAT(3), .WR_LAT(2)) u_dut_b (
    .clk(clk), .rst(rst_b), .req_valid(req_valid && sel), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .DM_CS(cs_b), .DM_OE(oe_b), .DM_WEB(web_b), .DM_A(a_b), .DM_DI(di_b), .DM_DO(dm_do),
    .mem_busy(busy_b), .rdata_valid(rv_b), .rdata(rd_b), .misalign_err(err_b)
`ifdef DM_PERF_CNT_EN
    , .load_cnt(lc_b), .stall_cnt(sc_b)
`endif
  );
  assign {m_cs, m_oe, m_web, m_a, m_di, m_busy, m_rv, m_rd, m_err} = sel ?
    {cs_b, oe_b, web_b, a_b, di_b, busy_b, rv_b, rd_b, err_b} :
    {cs_a, oe_a, web_a, a_a, di_a, busy_a, rv_a, rd_a, err_a};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic run(input string nm, input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [31:0] dov, input int exp_busy,
                     input logic exp_err, input logic [3:0] exp_web, input logic [31:0] exp_di,
                     input logic [13:0] exp_a, input logic [31:0] exp_rd);
    int busy = 0;
    logic cs_s = 1'b0, oe_s = 1'b0;
    logic [3:0] web_s = 4'hF;
    logic [31:0] di_s = '0;
    logic [13:0] a_s = '0;
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd; dm_do = dov; req_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (!m_busy) break;
      busy++;
      if (m_cs) begin
        cs_s = 1'b1; oe_s = m_oe; web_s = m_web; di_s = m_di; a_s = m_a;
      end
      @(negedge clk);
    end
    chk({nm, ".busy"}, busy, exp_busy);
    chk({nm, ".cs_done"}, m_cs, 0);
    chk({nm, ".err"}, m_err, exp_err);
    chk({nm, ".rv"}, m_rv, !we && !exp_err);
    chk({nm, ".cs"}, cs_s, !exp_err);
    if (!exp_err) begin
      chk({nm, ".oe"}, oe_s, !we);
      chk({nm, ".web"}, web_s, exp_web);
      chk({nm, ".addr"}, a_s, exp_a);
    end
    if (we && !exp_err) chk({nm, ".di"}, di_s, exp_di);
    if (!we || exp_err) chk({nm, ".rdata"}, m_rd, exp_rd);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    chk({nm, ".pulse_end"}, {m_rv, m_err, m_busy}, 0);
    @(negedge clk);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst.cs", cs_a, 0);
    chk("rst.web", web_a, 4'hF);
    chk("rst.busy", busy_a, 0);
    chk("rst.out", {rv_a, err_a, rd_a}, 0);
    rst_a = 1'b1; rst_b = 1'b1;
    @(negedge clk);
    run("lw",     0, 3'b010, 32'h100, 0, 32'h8000_00F0, 2, 0, 4'hF, 0, 14'h40, 32'h8000_00F0);
    run("lb",     0, 3'b000, 32'h103, 0, 32'h8012_3456, 2, 0, 4'hF, 0, 14'h40, 32'hFFFF_FF80);
    run("lbu",    0, 3'b100, 32'h103, 0, 32'h8012_3456, 2, 0, 4'hF, 0, 14'h40, 32'h0000_0080);
    run("lh",     0, 3'b001, 32'h102, 0, 32'h8012_3456, 2, 0, 4'hF, 0, 14'h40, 32'hFFFF_8012);
    run("lhu",    0, 3'b101, 32'h100, 0, 32'h1234_F00F, 2, 0, 4'hF, 0, 14'h40, 32'h0000_F00F);
    run("sh",     1, 3'b001, 32'h202, 32'h0000_1234, 0, 2, 0, 4'b0011, 32'h1234_1234, 14'h80, 0);
    run("sb",     1, 3'b000, 32'h201, 32'h0000_00AB, 0, 2, 0, 4'b1101, 32'hABAB_ABAB, 14'h80, 0);
    run("sw",     1, 3'b010, 32'h204, 32'hDEAD_BEEF, 0, 2, 0, 4'b0000, 32'hDEAD_BEEF, 14'h81, 0);
    run("lw_mis", 0, 3'b010, 32'h101, 0, 32'h1111_1111, 1, 1, 4'hF, 0, 0, 0);
    run("sh_mis", 1, 3'b001, 32'h203, 32'h5555, 0, 1, 1, 4'hF, 0, 0, 0);
    run("sbu_il", 1, 3'b100, 32'h100, 32'h5555, 0, 1, 1, 4'hF, 0, 0, 0);
    run("f3_011", 0, 3'b011, 32'h100, 0, 32'h2222_2222, 1, 1, 4'hF, 0, 0, 0);
    sel = 1'b1;
    run("b_lw",   0, 3'b010, 32'h100, 0, 32'h0000_ABCD, 4, 0, 4'hF, 0, 14'h40, 32'h0000_ABCD);
    run("b_sw",   1, 3'b010, 32'h204, 32'h0000_55AA, 0, 3, 0, 4'b0000, 32'h0000_55AA, 14'h81, 0);
    req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h108; dm_do = 32'h1234_5678; req_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("b_wait.busy", m_busy, 1);
    req_valid = 1'b0;
    rst_b = 1'b0;
    #1;
    chk("b_rst.ctl", {m_cs, m_oe, m_web}, 6'b00_1111);
    chk("b_rst.a", m_a, 0);
    chk("b_rst.di", m_di, 0);
    chk("b_rst.rd", m_rd, 0);
    chk("b_rst.flags", {m_busy, m_rv, m_err}, 0);
    @(negedge clk);
    #1;
    chk("b_rst.hold", {m_cs, m_busy}, 0);
    rst_b = 1'b1;
    @(negedge clk);
    run("b_lw2",  0, 3'b010, 32'h108, 0, 32'h1234_5678, 4, 0, 4'hF, 0, 14'h42, 32'h1234_5678);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
